// File: rtl/data_memory_ctrl.sv
// Byte-addressable RV64/RV32 data memory with size/sign handling, alignment and range
// checking, and a fixed-latency valid/ready request/response handshake.
module data_memory_ctrl #(
    parameter int XLEN    = 64,
    parameter int DEPTH   = 64,
    parameter int LATENCY = 1
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            req_valid,
    output logic            req_ready,
    input  logic            MemRead,
    input  logic            MemWrite,
    input  logic [2:0]      funct3,
    input  logic [XLEN-1:0] Mem_Addr,
    input  logic [XLEN-1:0] Write_Data,
    output logic            resp_valid,
    output logic [XLEN-1:0] Read_Data,
    output logic            resp_err,
    output logic [1:0]      dbg_state,
    output logic [3:0]      dbg_cnt
);

    localparam int NB = XLEN / 8;
    localparam int AW = $clog2(DEPTH);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    function automatic logic [8*DEPTH-1:0] preload_image();
        logic [8*DEPTH-1:0] img;
        img = '0;
        for (int i = 0; i < DEPTH / NB; i++) begin
            img[i*XLEN +: XLEN] = XLEN'(i + 1);
        end
        return img;
    endfunction

    localparam logic [8*DEPTH-1:0] PRELOAD = preload_image();

    // Power-up image only; reset deliberately leaves the array alone.
    logic [8*DEPTH-1:0] mem = PRELOAD;

    state_t          state, state_n;
    logic [3:0]      cnt, cnt_n;
    logic            live;
    logic            accept;
    logic [3:0]      size_b;
    logic [2:0]      sz_mask;
    logic [XLEN:0]   end_addr;
    logic            bad_f3, misaligned, out_of_range, req_err;
    logic [AW-1:0]   base;
    logic [AW-1:0]   byte_idx [NB];
    logic [XLEN-1:0] raw, load_val, rsp_data;
    logic            sign_bit, fill, rsp_err;

    // Handshake: a request transfers on a rising edge where req_valid && req_ready;
    // req_ready depends only on registered state, and resp_valid is a one-cycle pulse
    // per transferred request, arriving in order.
    assign req_ready  = live && (state != WAIT);
    assign resp_valid = (state == RESP);
    assign accept     = req_valid && req_ready;
    assign dbg_state  = state;
    assign dbg_cnt    = cnt;

    assign size_b       = 4'd1 << funct3[1:0];
    assign sz_mask      = 3'(size_b - 4'd1);
    assign base         = Mem_Addr[AW-1:0];
    assign bad_f3       = (funct3 == 3'b111) || ((XLEN == 32) && (funct3[1:0] == 2'b11));
    assign misaligned   = |(Mem_Addr[2:0] & sz_mask);
    // One extra bit so an address near the top of the space cannot wrap into range.
    assign end_addr     = {1'b0, Mem_Addr} + {{(XLEN-3){1'b0}}, size_b};
    assign out_of_range = end_addr > (XLEN+1)'(DEPTH);
    assign req_err      = (MemRead && MemWrite) || bad_f3 || (MemWrite && funct3[2])
                          || misaligned || out_of_range;

    always_comb begin
        raw = '0;
        for (int k = 0; k < NB; k++) begin
            byte_idx[k] = base + AW'(k);
            if (4'(k) < size_b) begin
                raw[8*k +: 8] = mem[{byte_idx[k], 3'b000} +: 8];
            end
        end
    end

    always_comb begin
        case (funct3[1:0])
            2'b00:   sign_bit = raw[7];
            2'b01:   sign_bit = raw[15];
            2'b10:   sign_bit = raw[31];
            default: sign_bit = raw[XLEN-1];
        endcase
        fill     = sign_bit && !funct3[2];
        load_val = raw;
        for (int b = 0; b < XLEN; b++) begin
            if (b >= 8 * int'(size_b)) begin
                load_val[b] = fill;
            end
        end
        rsp_data = (MemRead && !req_err) ? load_val : '0;
        rsp_err  = (MemRead || MemWrite) && req_err;
    end

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        case (state)
            IDLE, RESP: begin
                if (accept) begin
                    if (LATENCY == 1) begin
                        state_n = RESP;
                    end else begin
                        state_n = WAIT;
                        cnt_n   = 4'(LATENCY - 2);
                    end
                end else if (state == RESP) begin
                    state_n = IDLE;
                end
            end
            WAIT: begin
                if (cnt == 4'd0) begin
                    state_n = RESP;
                end else begin
                    cnt_n = cnt - 4'd1;
                end
            end
            default: begin
                state_n = IDLE;
                cnt_n   = '0;
            end
        endcase
    end

    // Load data is captured at accept, so later stores cannot disturb a pending load.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            cnt       <= '0;
            live      <= 1'b0;
            Read_Data <= '0;
            resp_err  <= 1'b0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
            live  <= 1'b1;
            if (accept) begin
                Read_Data <= rsp_data;
                resp_err  <= rsp_err;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (accept && MemWrite && !req_err) begin
            for (int k = 0; k < NB; k++) begin
                if (4'(k) < size_b) begin
                    mem[{byte_idx[k], 3'b000} +: 8] <= Write_Data[8*k +: 8];
                end
            end
        end
    end

endmodule

// File: tb/tb_data_memory_ctrl.sv
// Directed bench for data_memory_ctrl: a LATENCY=1 instance for data/extension/error
// behaviour and a LATENCY=3 instance for pipelined timing and reset during WAIT.
module tb_data_memory_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // LATENCY=1 instance
    logic        reset, req_valid, req_ready, MemRead, MemWrite, resp_valid, resp_err;
    logic [2:0]  funct3;
    logic [63:0] Mem_Addr, Write_Data, Read_Data;
    logic [1:0]  dbg_state;
    logic [3:0]  dbg_cnt;

    // LATENCY=3 instance
    logic        r3_reset, r3_valid, r3_ready, r3_rd, r3_wr, r3_resp_valid, r3_err;
    logic [2:0]  r3_f3;
    logic [63:0] r3_addr, r3_wdata, r3_rdata;
    logic [1:0]  r3_state;
    logic [3:0]  r3_cnt;

    data_memory_ctrl #(.XLEN(64), .DEPTH(64), .LATENCY(1)) u_dut (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
        .MemRead(MemRead), .MemWrite(MemWrite), .funct3(funct3), .Mem_Addr(Mem_Addr),
        .Write_Data(Write_Data), .resp_valid(resp_valid), .Read_Data(Read_Data),
        .resp_err(resp_err), .dbg_state(dbg_state), .dbg_cnt(dbg_cnt)
    );

    data_memory_ctrl #(.XLEN(64), .DEPTH(64), .LATENCY(3)) u_dut3 (
        .clk(clk), .reset(r3_reset), .req_valid(r3_valid), .req_ready(r3_ready),
        .MemRead(r3_rd), .MemWrite(r3_wr), .funct3(r3_f3), .Mem_Addr(r3_addr),
        .Write_Data(r3_wdata), .resp_valid(r3_resp_valid), .Read_Data(r3_rdata),
        .resp_err(r3_err), .dbg_state(r3_state), .dbg_cnt(r3_cnt)
    );

    logic [63:0] exp_q[$];
    int          acc_q[$];
    logic [63:0] mon_e;
    int          mon_a;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // One LATENCY=1 transaction: present at a falling edge, check the response one cycle later.
    task automatic req1(input string tag, input logic rd, input logic wr, input logic [2:0] f3,
                        input logic [63:0] addr, input logic [63:0] wdata,
                        input logic [63:0] exp_data, input logic exp_err);
        @(negedge clk);
        check_eq({tag, "_idle"}, resp_valid, 1'b0);
        check_eq({tag, "_ready"}, req_ready, 1'b1);
        req_valid  = 1'b1;
        MemRead    = rd;
        MemWrite   = wr;
        funct3     = f3;
        Mem_Addr   = addr;
        Write_Data = wdata;
        @(negedge clk);
        req_valid = 1'b0;
        MemRead   = 1'b0;
        MemWrite  = 1'b0;
        check_eq({tag, "_valid"}, resp_valid, 1'b1);
        check_eq({tag, "_data"}, Read_Data, exp_data);
        check_eq({tag, "_err"}, resp_err, exp_err);
    endtask

    // Scoreboard for the LATENCY=3 instance: data, error flag and accept-to-response latency.
    always @(negedge clk) begin
        if (r3_resp_valid) begin
            if (exp_q.size() == 0) begin
                check_eq("r3_unexpected", r3_resp_valid, 1'b0);
            end else begin
                mon_e = exp_q.pop_front();
                mon_a = acc_q.pop_front();
                check_eq("r3_data", r3_rdata, mon_e);
                check_eq("r3_err", r3_err, 1'b0);
                check_eq("r3_lat", 64'(cyc - mon_a), 64'd3);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1; req_valid = 1'b0; MemRead = 1'b0; MemWrite = 1'b0;
        funct3 = 3'b000; Mem_Addr = '0; Write_Data = '0;
        r3_reset = 1'b1; r3_valid = 1'b0; r3_rd = 1'b0; r3_wr = 1'b0;
        r3_f3 = 3'b011; r3_addr = '0; r3_wdata = '0;

        repeat (2) @(negedge clk);
        check_eq("rst_ready", req_ready, 1'b0);
        check_eq("rst_valid", resp_valid, 1'b0);
        check_eq("rst_data", Read_Data, 64'd0);
        check_eq("rst_err", resp_err, 1'b0);
        check_eq("rst_state", dbg_state, 2'd0);
        check_eq("rst_cnt", dbg_cnt, 4'd0);
        check_eq("r3_rst_ready", r3_ready, 1'b0);
        reset    = 1'b0;
        r3_reset = 1'b0;

        // Preload image
        req1("ld8",  1, 0, 3'b011, 64'd8,  0, 64'd2, 0);
        req1("ld56", 1, 0, 3'b011, 64'd56, 0, 64'd8, 0);

        // Error cases, each followed by a load proving memory is intact
        req1("lw_mis",  1, 0, 3'b010, 64'd2, 0, 0, 1);
        req1("ld0_a",   1, 0, 3'b011, 64'd0, 0, 64'd1, 0);
        req1("sd_mis",  0, 1, 3'b011, 64'd4, 64'hDEADBEEFCAFEF00D, 0, 1);
        req1("ld0_b",   1, 0, 3'b011, 64'd0, 0, 64'd1, 0);
        req1("ld_oor",  1, 0, 3'b011, 64'd64, 0, 0, 1);
        req1("ld0_c",   1, 0, 3'b011, 64'd0, 0, 64'd1, 0);
        req1("ld_wrap", 1, 0, 3'b011, 64'hFFFFFFFFFFFFFFF8, 0, 0, 1);
        req1("ld0_d",   1, 0, 3'b011, 64'd0, 0, 64'd1, 0);
        req1("f3_111",  1, 0, 3'b111, 64'd0, 0, 0, 1);
        req1("ld0_e",   1, 0, 3'b011, 64'd0, 0, 64'd1, 0);
        req1("rd_wr",   1, 1, 3'b011, 64'd0, 64'h5555555555555555, 0, 1);
        req1("ld0_f",   1, 0, 3'b011, 64'd0, 0, 64'd1, 0);
        req1("st_uns",  0, 1, 3'b101, 64'd0, 64'hFFFF, 0, 1);
        req1("ld0_g",   1, 0, 3'b011, 64'd0, 0, 64'd1, 0);
        req1("nop",     0, 0, 3'b011, 64'd8, 0, 0, 0);

        // Byte store into the low doubleword
        req1("sb3",    0, 1, 3'b000, 64'd3, 64'hAB, 0, 0);
        req1("ld0_sb", 1, 0, 3'b011, 64'd0, 0, 64'h00000000AB000001, 0);

        // Extension
        req1("sh16",  0, 1, 3'b001, 64'd16, 64'h8001, 0, 0);
        req1("lh16",  1, 0, 3'b001, 64'd16, 0, 64'hFFFFFFFFFFFF8001, 0);
        req1("lhu16", 1, 0, 3'b101, 64'd16, 0, 64'h0000000000008001, 0);
        req1("lb17",  1, 0, 3'b000, 64'd17, 0, 64'hFFFFFFFFFFFFFF80, 0);
        req1("lbu17", 1, 0, 3'b100, 64'd17, 0, 64'h0000000000000080, 0);
        req1("lw16",  1, 0, 3'b010, 64'd16, 0, 64'h0000000000008001, 0);
        req1("sb23",  0, 1, 3'b000, 64'd23, 64'hF0, 0, 0);
        req1("ld16",  1, 0, 3'b011, 64'd16, 0, 64'hF000000000008001, 0);
        req1("lw20",  1, 0, 3'b010, 64'd20, 0, 64'hFFFFFFFFF0000000, 0);
        req1("lwu20", 1, 0, 3'b110, 64'd20, 0, 64'h00000000F0000000, 0);

        // Back-to-back store then load at the same address
        @(negedge clk);
        req_valid = 1'b1; MemRead = 1'b0; MemWrite = 1'b1; funct3 = 3'b011;
        Mem_Addr = 64'd24; Write_Data = 64'h1122334455667788;
        @(negedge clk);
        check_eq("b2b_st_valid", resp_valid, 1'b1);
        check_eq("b2b_st_err", resp_err, 1'b0);
        check_eq("b2b_st_data", Read_Data, 64'd0);
        check_eq("b2b_ready", req_ready, 1'b1);
        MemRead = 1'b1; MemWrite = 1'b0; Write_Data = '0;
        @(negedge clk);
        req_valid = 1'b0; MemRead = 1'b0;
        check_eq("b2b_ld_valid", resp_valid, 1'b1);
        check_eq("b2b_ld_data", Read_Data, 64'h1122334455667788);
        check_eq("b2b_ld_err", resp_err, 1'b0);
        @(negedge clk);
        check_eq("b2b_end", resp_valid, 1'b0);

        // LATENCY=3: four loads with req_valid held high
        r3_valid = 1'b1; r3_rd = 1'b1; r3_f3 = 3'b011;
        for (int n = 0; n < 4; n++) begin
            r3_addr = 64'(8 * n);
            check_eq("r3_ready_acc", r3_ready, 1'b1);
            exp_q.push_back(64'(n + 1));
            acc_q.push_back(cyc);
            @(negedge clk);
            check_eq("r3_wait0_ready", r3_ready, 1'b0);
            check_eq("r3_wait0_cnt", r3_cnt, 4'd1);
            @(negedge clk);
            check_eq("r3_wait1_ready", r3_ready, 1'b0);
            check_eq("r3_wait1_cnt", r3_cnt, 4'd0);
            @(negedge clk);
        end
        r3_valid = 1'b0; r3_rd = 1'b0;
        repeat (4) @(negedge clk);
        check_eq("r3_drain", 64'(exp_q.size()), 64'd0);

        // LATENCY=3: reset while in WAIT discards the pending response
        r3_valid = 1'b1; r3_rd = 1'b1; r3_addr = 64'd8;
        check_eq("r3_rw_ready", r3_ready, 1'b1);
        @(negedge clk);
        r3_valid = 1'b0; r3_rd = 1'b0;
        check_eq("r3_rw_in_wait", r3_state, 2'd1);
        r3_reset = 1'b1;
        #1;
        check_eq("r3_rw_state", r3_state, 2'd0);
        check_eq("r3_rw_ready_lo", r3_ready, 1'b0);
        @(negedge clk);
        check_eq("r3_rw_novalid0", r3_resp_valid, 1'b0);
        r3_reset = 1'b0;
        @(negedge clk);
        check_eq("r3_rw_ready_hi", r3_ready, 1'b1);
        check_eq("r3_rw_idle", r3_state, 2'd0);
        for (int i = 0; i < 4; i++) begin
            check_eq("r3_rw_novalid", r3_resp_valid, 1'b0);
            @(negedge clk);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/data_memory_ctrl.md
# data_memory_ctrl

Parametrised, byte-addressable data memory for the RISC-V datapath. It supports RV64 load/store sizes (byte, half, word, double) selected by funct3, with sign or zero extension, alignment and range checking, and a configurable-latency valid/ready request/response handshake. It sits in the MEM stage in place of the fixed 64-byte, doubleword-only memory, and the core stalls on `req_ready`/`resp_valid`.

## Interface
- `XLEN`, 64: data and address width in bits. Must be 32 or 64.
- `DEPTH`, 64: memory size in bytes. Power of two, at least XLEN/8.
- `LATENCY`, 1: cycles from the accept edge to the response. Legal range 1..15.
- `clk` in 1: single clock; all state updates on the rising edge.
- `reset` in 1: asynchronous, active-high reset.
- `req_valid` in 1: request present.
- `req_ready` out 1: block can accept a request this cycle.
- `MemRead` in 1: request is a load.
- `MemWrite` in 1: request is a store.
- `funct3` in 3: bits [1:0] select the size, 1/2/4/8 bytes; bit 2 selects an unsigned load.
- `Mem_Addr` in XLEN: byte address.
- `Write_Data` in XLEN: store data; the low 8*size bits are used.
- `resp_valid` out 1: one-cycle pulse per accepted request.
- `Read_Data` out XLEN: load result, extended to XLEN.
- `resp_err` out 1: error flag, valid while `resp_valid` is high.

## Operation
- Storage: DEPTH bytes, little-endian.
  - Time-zero preload: all bytes are 0, then the XLEN-wide word i holds i+1 for every i.
  - `reset` never modifies memory contents.
- Accept: a request is accepted on a rising edge where `req_valid` and `req_ready` are both 1.
  - If `MemRead` and `MemWrite` are both 0, the request is accepted and gets a response with `resp_err`=0 and `Read_Data`=0.
- Size: size = 1 << funct3[1:0] bytes.
- An accepted request is an error if any of the following holds:
  - `MemRead` and `MemWrite` are both 1.
  - funct3 is 3'b111, or is 3'b011 when XLEN=32.
  - `funct3`[2]=1 on a store.
  - `Mem_Addr` mod size is not 0 (misaligned).
  - `Mem_Addr` + size > DEPTH. This is evaluated at XLEN+1 bits, so there is no wrap-around.
- On an error, no memory write occurs, the response has `resp_err`=1 and `Read_Data`=0.
- Store: on the accept edge, bytes `Mem_Addr`..`Mem_Addr`+size-1 are written with `Write_Data`[8*size-1:0]. The response has `Read_Data`=0.
- Load: bytes are sampled on the accept edge into the pending-response register.
  - A store accepted later never alters an already-captured load.
  - Result is sign-extended if `funct3`[2]=0, zero-extended if `funct3`[2]=1.
- FSM states:
  - IDLE: `req_ready`=1.
  - WAIT: `req_ready`=0; counter `cnt` decrements each cycle.
  - RESP: `resp_valid`=1, `req_ready`=1.
- FSM transitions:
  - From IDLE or RESP, on accept: go to RESP if LATENCY=1; otherwise go to WAIT with `cnt`=LATENCY-2.
  - WAIT: go to RESP when `cnt`=0, else decrement `cnt`.
  - RESP without accept: go to IDLE.
- Back-to-back: with LATENCY=1, one request per cycle is sustained.

## Timing
- Reset values, held while `reset`=1:
  - FSM state IDLE, `cnt`=0.
  - `req_ready`=0, `resp_valid`=0, `resp_err`=0, `Read_Data`=0.
- `req_ready` rises in the first cycle after `reset` deasserts.
- Latency: accept on edge E0, so `resp_valid`, `Read_Data` and `resp_err` are valid in the cycle after edge E0+LATENCY-1. `resp_valid` lasts exactly one cycle.
- `Read_Data` and `resp_err` are registered. They hold their last value outside RESP, and the bench checks them only when `resp_valid`=1.
- `req_ready` is decoded from the FSM state only; it has no combinational dependence on `req_valid`.
- Reset mid-operation (WAIT or RESP):
  - The pending response is discarded; no `resp_valid` pulse follows.
  - A store already accepted remains written.
- Same-address store then load on consecutive accepts: the load returns the new data.

## Test plan
- Preload, XLEN=64, DEPTH=64, LATENCY=1: load with `funct3`=011 at address 8 gives `resp_valid` on the next cycle with `Read_Data`=2 and `resp_err`=0. At address 56 it gives 8.
- Byte store then doubleword load: store byte 0xAB at address 3 (`funct3`=000), then load doubleword at address 0. `Read_Data`=0x00000000AB000001.
- Extension: store half 0x8001 at address 16 (`funct3`=001).
  - `lh` at 16 gives 0xFFFFFFFFFFFF8001.
  - `lhu` at 16 gives 0x0000000000008001.
  - `lb` at 17 gives 0xFFFFFFFFFFFFFF80.
  - `lbu` at 17 gives 0x80.
- Errors: each case gives `resp_err`=1 and `Read_Data`=0, and a follow-up load of address 0 still returns 1.
  - `lw` at address 2 (misaligned).
  - `sd` at address 4 (misaligned); memory is left unchanged.
  - `ld` at address 64 (out of range).
  - `ld` at address 0xFFFFFFFFFFFFFFF8 (no wrap).
  - `funct3`=111.
  - `MemRead`=`MemWrite`=1.
- LATENCY=3 instance:
  - Hold `req_valid`=1 for 4 requests: `req_ready` is 0 for the 2 WAIT cycles after each accept, and each response arrives 3 edges after its accept, in order.
  - Assert `reset` during WAIT: no `resp_valid` pulse follows, the FSM is in IDLE, and `req_ready`=1 one cycle after release.
